// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: round-robin arbitration into a single-entry result slot.
// An accepted operation is evaluated combinationally and registered, giving one cycle of latency.
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [3:0]              req0_op,
    input  logic signed [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0]        req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [3:0]              req1_op,
    input  logic signed [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0]        req1_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH:0]          rsp_data,
    output logic                    rsp_id,
    output logic                    rsp_err
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_LT  = 4'd4;
    localparam logic [3:0] OP_LE  = 4'd5;
    localparam logic [3:0] OP_EQ  = 4'd6;
    localparam logic [3:0] OP_NE  = 4'd7;
    localparam logic [3:0] OP_GT  = 4'd8;
    localparam logic [3:0] OP_GE  = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;

    localparam logic [WIDTH:0] SHL_LIM = (WIDTH+1)'(WIDTH + 1);
    localparam logic [WIDTH:0] SHR_LIM = (WIDTH+1)'(WIDTH);

    // Returns {err, result}; result is the exact WIDTH+1-bit value.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [3:0]              op,
        input logic signed [WIDTH-1:0] a,
        input logic [WIDTH-1:0]        b
    );
        logic signed [WIDTH:0]   a_x;
        logic signed [WIDTH:0]   b_x;
        logic signed [WIDTH-1:0] b_s;
        logic [WIDTH:0]          b_w;
        logic [WIDTH:0]          res;
        logic                    err;
        a_x = {a[WIDTH-1], a};
        b_x = {b[WIDTH-1], b};
        b_s = signed'(b);
        b_w = {1'b0, b};
        res = '0;
        err = 1'b0;
        case (op)
            OP_AND: res = {1'b0, a & b_s};
            OP_OR:  res = {1'b0, a | b_s};
            OP_ADD: res = a_x + b_x;
            OP_SUB: res = a_x - b_x;
            OP_LT:  res = {{WIDTH{1'b0}}, (a <  b_s)};
            OP_LE:  res = {{WIDTH{1'b0}}, (a <= b_s)};
            OP_EQ:  res = {{WIDTH{1'b0}}, (a == b_s)};
            OP_NE:  res = {{WIDTH{1'b0}}, (a != b_s)};
            OP_GT:  res = {{WIDTH{1'b0}}, (a >  b_s)};
            OP_GE:  res = {{WIDTH{1'b0}}, (a >= b_s)};
            OP_SHL: begin
                if (b_w >= SHL_LIM) res = '0;
                else                res = a_x << b;
            end
            OP_SHR: begin
                if (b_w >= SHR_LIM) res = {(WIDTH+1){a[WIDTH-1]}};
                else                res = a_x >>> b;
            end
            default: err = 1'b1;
        endcase
        return {err, res};
    endfunction

    logic                    slot_free;
    logic                    last_grant;
    logic                    prio0;
    logic                    grant0;
    logic                    grant1;
    logic                    vld_p0;
    logic [3:0]              op_p0;
    logic signed [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0]        b_p0;
    logic [WIDTH+1:0]        eval_p0;

    logic                    vld_p1;
    logic [WIDTH:0]          data_p1;
    logic                    id_p1;
    logic                    err_p1;

    // Stage p0: arbitration and operand select; readiness never looks at the requester's own valid.
    always_comb begin
        slot_free  = !vld_p1 || rsp_ready;
        prio0      = last_grant;
        req0_ready = !rst && slot_free && (prio0 || !req1_valid);
        req1_ready = !rst && slot_free && (!prio0 || !req0_valid);
        grant0     = req0_valid && req0_ready;
        grant1     = req1_valid && req1_ready;
        vld_p0     = grant0 || grant1;
        op_p0      = grant1 ? req1_op : req0_op;
        a_p0       = grant1 ? req1_a  : req0_a;
        b_p0       = grant1 ? req1_b  : req0_b;
        eval_p0    = alu_eval(op_p0, a_p0, b_p0);
    end

    // Stage p1: result slot; reset clears data too so the output is deterministic.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            id_p1      <= 1'b0;
            err_p1     <= 1'b0;
            last_grant <= 1'b1;
        end else if (vld_p0) begin
            vld_p1     <= 1'b1;
            data_p1    <= eval_p0[WIDTH:0];
            id_p1      <= grant1;
            err_p1     <= eval_p0[WIDTH+1];
            last_grant <= grant1;
        end else if (rsp_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_data  = data_p1;
    assign rsp_id    = id_p1;
    assign rsp_err   = err_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter at WIDTH=4 with hand-computed results.
module tb_alu_arbiter;
    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready;
    logic [3:0]        req0_op;
    logic signed [3:0] req0_a;
    logic [3:0]        req0_b;
    logic              req1_valid, req1_ready;
    logic [3:0]        req1_op;
    logic signed [3:0] req1_a;
    logic [3:0]        req1_b;
    logic              rsp_valid, rsp_ready;
    logic [4:0]        rsp_data;
    logic              rsp_id, rsp_err;

    int total = 0;
    int bad = 0;

    alu_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic port, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [4:0] exp, input logic exp_err,
                         input string tag);
        if (!port) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
        chk({tag, "_id"}, 32'(rsp_id), 32'(port));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    task automatic contend();
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 4'h1; req0_b = 4'h1;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 4'h2; req1_b = 4'h2;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        contend();

        // Reset with both requesters pushing
        tick();
        chk("rst_vld0", 32'(rsp_valid), 32'd0);
        tick();
        chk("rst_vld1", 32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy0", 32'(req0_ready), 32'd1);
        chk("post_rst_rdy1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("idle_vld", 32'(rsp_valid), 32'd0);

        // Function vectors
        issue(1'b0, 4'd2,  4'h7, 4'h1, 5'h08, 1'b0, "add");
        issue(1'b0, 4'd3,  4'h8, 4'h1, 5'h17, 1'b0, "sub");
        issue(1'b0, 4'd11, 4'h8, 4'h2, 5'h1E, 1'b0, "shr");
        issue(1'b0, 4'd10, 4'h3, 4'h3, 5'h18, 1'b0, "shl");
        issue(1'b0, 4'd10, 4'h3, 4'hF, 5'h00, 1'b0, "shl_big");
        issue(1'b1, 4'd11, 4'h9, 4'h5, 5'h1F, 1'b0, "shr_big");
        issue(1'b0, 4'hC,  4'h7, 4'h1, 5'h00, 1'b1, "illegal");
        issue(1'b1, 4'd0,  4'hC, 4'hA, 5'h08, 1'b0, "and");
        issue(1'b0, 4'd1,  4'h5, 4'hA, 5'h0F, 1'b0, "or");
        issue(1'b1, 4'd4,  4'hF, 4'h1, 5'h01, 1'b0, "lt");
        issue(1'b0, 4'd9,  4'hF, 4'h1, 5'h00, 1'b0, "ge");
        issue(1'b0, 4'd6,  4'h5, 4'h5, 5'h01, 1'b0, "eq");
        issue(1'b1, 4'd8,  4'h7, 4'h8, 5'h01, 1'b0, "gt");
        issue(1'b1, 4'd2,  4'h8, 4'h8, 5'h10, 1'b0, "add_neg");

        // Round-robin under continuous contention; last grant was requester 1
        contend();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_vld", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(i % 2));
            chk("rr_data", 32'(rsp_data), (i % 2 == 0) ? 32'h02 : 32'h04);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("drain_vld", 32'(rsp_valid), 32'd0);

        // Backpressure: held result ignores changing requests
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 4'h7; req0_b = 4'h1;
        tick();
        req0_a = 4'h2;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 4'h2; req1_b = 4'h2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'h08);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_rdy0", 32'(req0_ready), 32'd0);
            chk("bp_rdy1", 32'(req1_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("bp_rel_vld", 32'(rsp_valid), 32'd1);
        chk("bp_rel_data", 32'(rsp_data), 32'h04);
        chk("bp_rel_id", 32'(rsp_id), 32'd1);

        // Reset mid-operation with last grant = requester 1
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_vld", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        contend();
        tick();
        chk("mid_rst_grant_a", 32'(rsp_id), 32'd0);

        // Reset mid-operation with last grant = requester 0
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        chk("hold_before_rst", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst2_vld", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        contend();
        tick();
        chk("mid_rst_grant_b", 32'(rsp_id), 32'd0);
        chk("mid_rst_grant_b_data", 32'(rsp_data), 32'h02);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
